// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer for a small in-order pipeline. It launches a run
//   from START_ADDR and steps the PC by STEP each cycle. A taken branch
//   redirects the PC and raises a flush window of FLUSH_CYCLES non-stalled
//   cycles. Stalls hold the PC. The run halts when the PC reaches END_ADDR.
//   The sequencer also counts active cycles and stalled cycles.
//
// Ports
//   clk           : clock, all state updates on the rising edge
//   rst           : synchronous active-low reset
//   start         : launch a run (honoured in IDLE or HALT only)
//   stall         : hold the PC this cycle
//   branch_taken  : redirect request from execute (ignored while flushing)
//   branch_target : redirect address
//   pc_cur        : current value of the external PC register
//   pc_load       : load enable for the PC register (combinational)
//   pc_next       : value to load into the PC register (combinational)
//   flush         : kill wrong-path instructions (registered, high in FLUSH)
//   running       : high in RUN or FLUSH (registered)
//   done          : high in HALT (registered)
//   cycle_count   : cycles spent in RUN plus FLUSH, saturating
//   stall_count   : stalled cycles in RUN or FLUSH, saturating
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module pc_sequencer #(
    parameter logic [31:0] START_ADDR   = 32'd0,
    parameter logic [31:0] END_ADDR     = 32'd131,
    parameter logic [31:0] STEP         = 32'd1,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] pc_cur,
    output logic        pc_load,
    output logic [31:0] pc_next,
    output logic        flush,
    output logic        running,
    output logic        done,
    output logic [31:0] cycle_count,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] flush_cnt;
    logic [2:0] flush_cnt_nxt;
    logic       clear_counts;
    logic       stall_hit;
    logic       active;

    assign active = (state == RUN) || (state == FLUSH);

    // Next-state and PC-update decision. The priority order inside RUN/FLUSH
    // is branch (RUN only) > stall > end-of-program > sequential step, so a
    // stall that coincides with a taken branch never delays the redirect.
    // Leaving FLUSH is decided on the cycle the counter steps from 1 to 0,
    // which yields exactly FLUSH_CYCLES non-stalled flush cycles.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        pc_load       = 1'b0;
        pc_next       = pc_cur;
        clear_counts  = 1'b0;
        stall_hit     = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    pc_load      = 1'b1;
                    pc_next      = START_ADDR;
                    state_nxt    = RUN;
                    clear_counts = 1'b1;
                end
            end
            RUN, FLUSH: begin
                if ((state == RUN) && branch_taken) begin
                    pc_load       = 1'b1;
                    pc_next       = branch_target;
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FLUSH_LOAD;
                end else if (stall) begin
                    stall_hit = 1'b1;
                end else if (pc_cur == END_ADDR) begin
                    state_nxt     = HALT;
                    flush_cnt_nxt = 3'd0;
                end else begin
                    pc_load = 1'b1;
                    pc_next = pc_cur + STEP;
                    if (state == FLUSH) begin
                        flush_cnt_nxt = flush_cnt - 3'd1;
                        if (flush_cnt <= 3'd1) begin
                            state_nxt     = RUN;
                            flush_cnt_nxt = 3'd0;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // The PC register must never be written while reset is asserted.
        if (!rst) begin
            pc_load = 1'b0;
        end
    end

    // State register, registered status decodes and the saturating counters.
    // The counters clear on the launching start and otherwise hold outside
    // RUN/FLUSH, so HALT keeps the last run's figures for readout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            flush_cnt   <= 3'd0;
            flush       <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            cycle_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            flush     <= (state_nxt == FLUSH);
            running   <= (state_nxt == RUN) || (state_nxt == FLUSH);
            done      <= (state_nxt == HALT);
            if (clear_counts) begin
                cycle_count <= 32'd0;
                stall_count <= 32'd0;
            end else if (active) begin
                if (cycle_count != 32'hFFFF_FFFF) begin
                    cycle_count <= cycle_count + 32'd1;
                end
                if (stall_hit && (stall_count != 32'hFFFF_FFFF)) begin
                    stall_count <= stall_count + 32'd1;
                end
            end
        end
    end

endmodule
